xunit_sha_round: RTL



---
 rtl/sha256_pkg.sv | 64 ++++++
 rtl/sha256_round_step.sv | 30 +++
 rtl/xunit_sha_round.sv | 116 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, working-state types and round helper functions.
// Shared by the compression round unit and its combinational step.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t vec8_t [8];

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ROUND,
    FINAL
  } state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam vec8_t IV256 = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam vec8_t IV224 = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t sigma1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(word_t e, word_t f, word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(word_t a, word_t b, word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One SHA-256 compression round, purely combinational.
// Index 0..7 of the state vectors holds working words a..h.
module sha256_round_step
  import sha256_pkg::*;
(
  input  vec8_t cur,
  input  word_t w,
  input  word_t k,
  output vec8_t nxt
);

  word_t t1;
  word_t t2;

  // next working state from current a..h, schedule word and constant
  always_comb begin
    t1 = cur[7] + sigma1(cur[4]) + ch(cur[4], cur[5], cur[6])
       + k + w;
    t2 = sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
    nxt[0] = t1 + t2;
    nxt[1] = cur[0];
    nxt[2] = cur[1];
    nxt[3] = cur[2];
    nxt[4] = cur[3] + t1;
    nxt[5] = cur[4];
    nxt[6] = cur[5];
    nxt[7] = cur[6];
  end

endmodule

// File: rtl/xunit_sha_round.sv
// SHA-256 compression unit fed by the message-schedule stream.
// XUNIT_SHA_ROUND_SHA224_EN adds the sha224 port and SHA-224 IV.
module xunit_sha_round
  import sha256_pkg::*;
#(
  parameter int DELAY_W = 7,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7,
  input  logic [DELAY_W-1:0] delay0,
`ifdef XUNIT_SHA_ROUND_SHA224_EN
  input  logic               sha224,
`endif
  input  logic               init_hash
);

  state_t               state;
  vec8_t                hreg;
  vec8_t                work;
  vec8_t                nxt;
  vec8_t                iv;
  logic [5:0]           round;
  logic [DELAY_W-1:0]   delay;
  logic                 mode224;

  sha256_round_step u_step (
    .cur (work),
    .w   (in0),
    .k   (K[round]),
    .nxt (nxt)
  );

  // initial value selected by the hash mode at run
  always_comb begin
    iv = IV256;
`ifdef XUNIT_SHA_ROUND_SHA224_EN
    if (sha224) iv = IV224;
`endif
  end

  // control FSM, working state and chaining registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hreg    <= IV256;
      work    <= '{default: '0};
      round   <= '0;
      delay   <= '0;
      done    <= 1'b1;
      mode224 <= 1'b0;
    end else if (run) begin
      if (init_hash) begin
        hreg <= iv;
        work <= iv;
`ifdef XUNIT_SHA_ROUND_SHA224_EN
        mode224 <= sha224;
`endif
      end else begin
        work <= hreg;
      end
      delay <= delay0;
      round <= '0;
      done  <= 1'b0;
      state <= WAIT;
    end else begin
      unique case (state)
        IDLE: ;
        WAIT: begin
          if (delay != '0) begin
            delay <= delay - 1'b1;
          end else if (running) begin
            work  <= nxt;
            round <= round + 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (running) begin
            work  <= nxt;
            round <= round + 1'b1;
            if (round == 6'd63) state <= FINAL;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++)
            hreg[i] <= hreg[i] + work[i];
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign out0 = hreg[0];
  assign out1 = hreg[1];
  assign out2 = hreg[2];
  assign out3 = hreg[3];
  assign out4 = hreg[4];
  assign out5 = hreg[5];
  assign out6 = hreg[6];
  assign out7 = mode224 ? '0 : hreg[7];

endmodule
